// File: rtl/inta_sequencer.sv
// inta_sequencer: runs the two-pulse INTA acknowledge cycle toward the PIC and
// hands the captured {TReg, IR} vector to the core over valid/ready.
module inta_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic       IEN,
    input  logic [7:0] dataBus,
    output logic       INTA,
    output logic [7:0] vector,
    output logic       vectorValid,
    input  logic       vectorReady,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, PULSE1, GAP, PULSE2, DELIVER, HOLDOFF} state_t;
    localparam logic [3:0] PL = 4'(PULSE_CYCLES);
    localparam logic [3:0] GL = 4'(GAP_CYCLES);
    state_t state, state_n;
    logic [1:0] sync;
    logic intSync;
    logic [3:0] cnt, cnt_n;
    logic inta_n, valid_n, last;
    logic [7:0] vector_n;
    assign intSync = sync[1];
    assign last = cnt == 4'd1;
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        inta_n   = INTA;
        valid_n  = vectorValid;
        vector_n = vector;
        case (state)
            IDLE: if (intSync && IEN) begin
                state_n = PULSE1;
                inta_n  = 1'b0;
                cnt_n   = PL;
            end
            PULSE1: if (last) begin
                state_n = GAP;
                inta_n  = 1'b1;
                cnt_n   = GL;
            end else cnt_n = cnt - 4'd1;
            GAP: if (last) begin
                state_n = PULSE2;
                inta_n  = 1'b0;
                cnt_n   = PL;
            end else cnt_n = cnt - 4'd1;
            PULSE2: if (last) begin
                state_n  = DELIVER;
                inta_n   = 1'b1;
                valid_n  = 1'b1;
                vector_n = dataBus;
                cnt_n    = 4'd0;
            end else cnt_n = cnt - 4'd1;
            // vectorReady only matters here, where vectorValid is high
            DELIVER: if (vectorReady) begin
                state_n = HOLDOFF;
                valid_n = 1'b0;
                cnt_n   = GL;
            end
            HOLDOFF: if (last) begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end else cnt_n = cnt - 4'd1;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= 2'b00;
            state       <= IDLE;
            cnt         <= 4'd0;
            INTA        <= 1'b1;
            vector      <= 8'h00;
            vectorValid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync        <= {sync[0], INT};
            state       <= state_n;
            cnt         <= cnt_n;
            INTA        <= inta_n;
            vector      <= vector_n;
            vectorValid <= valid_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: PIC model plus scoreboard of expected vectors for inta_sequencer.
module tb_inta_sequencer;
    localparam int P = 2;
    localparam int G = 2;
    logic clk = 0, reset = 1, INT = 0, IEN = 0, vectorReady = 0;
    logic [7:0] dataBus, vector, pic_vec = 8'h00;
    logic INTA, vectorValid, busy;
    logic inta_q = 1;
    int pulse_no = 0, falls = 0, n_checks = 0, n_fail = 0, f0;
    logic [7:0] exp_q[$];

    inta_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .INT(INT), .IEN(IEN), .dataBus(dataBus),
        .INTA(INTA), .vector(vector), .vectorValid(vectorValid),
        .vectorReady(vectorReady), .busy(busy)
    );

    always #5 clk = ~clk;
    assign dataBus = (pulse_no == 2 && !INTA) ? pic_vec : 8'hFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!vectorValid && k < 50) begin cyc(1); k++; end
        check("valid_timeout", vectorValid, 1);
    endtask

    task automatic wait_inta(input logic lvl);
        int k = 0;
        while (INTA !== lvl && k < 50) begin cyc(1); k++; end
        check("inta_timeout", INTA, lvl);
    endtask

    task automatic accept();
        vectorReady = 1;
        cyc(1);
        check("valid_drop", vectorValid, 0);
        vectorReady = 0;
    endtask

    // PIC model and scoreboard consumer: sample away from the rising edge
    always @(negedge clk) begin
        if (reset) pulse_no = 0;
        else if (inta_q && !INTA) begin
            pulse_no = (pulse_no == 2) ? 1 : pulse_no + 1;
            falls++;
        end
        inta_q = INTA;
        if (!reset && vectorValid && vectorReady) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else check("sb_vector", vector, exp_q.pop_front());
        end
    end

    initial begin
        cyc(2);
        reset = 0;
        check("rst_inta", INTA, 1);
        check("rst_valid", vectorValid, 0);
        check("rst_vector", vector, 8'h00);
        check("rst_busy", busy, 0);
        // basic sequence with latency and pulse shape
        pic_vec = 8'hA5; exp_q.push_back(8'hA5); f0 = falls;
        INT = 1; IEN = 1;
        cyc(1); check("lat1", INTA, 1);
        cyc(1); check("lat2", INTA, 1);
        cyc(1); check("lat3", INTA, 0); check("busy_on", busy, 1);
        for (int i = 1; i < P; i++) begin cyc(1); check("p1_low", INTA, 0); end
        for (int i = 0; i < G; i++) begin cyc(1); check("gap_high", INTA, 1); end
        for (int i = 0; i < P; i++) begin cyc(1); check("p2_low", INTA, 0); end
        check("pre_valid", vectorValid, 0);
        cyc(1);
        check("cap_inta", INTA, 1);
        check("cap_valid", vectorValid, 1);
        check("cap_vector", vector, 8'hA5);
        // stall delivery
        INT = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("stall_valid", vectorValid, 1);
            check("stall_vector", vector, 8'hA5);
            check("stall_inta", INTA, 1);
            check("stall_falls", falls - f0, 2);
        end
        accept();
        for (int i = 1; i < G; i++) begin cyc(1); check("holdoff_busy", busy, 1); end
        cyc(1); check("idle_busy", busy, 0);
        check("hold_vector", vector, 8'hA5);
        // INT with IEN low is held off
        INT = 1; IEN = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("ien0_inta", INTA, 1);
            check("ien0_busy", busy, 0);
        end
        pic_vec = 8'h3C; exp_q.push_back(8'h3C); f0 = falls;
        IEN = 1;
        cyc(1); check("ien_rise", INTA, 0);
        INT = 0;
        wait_valid();
        check("ien_vector", vector, 8'h3C);
        accept();
        cyc(G);
        check("ien_falls", falls - f0, 2);
        check("ien_idle", busy, 0);
        // INT drops on first INTA, IEN drops in GAP
        pic_vec = 8'hC7; exp_q.push_back(8'hC7); f0 = falls;
        INT = 1; IEN = 1;
        wait_inta(0);
        INT = 0;
        wait_inta(1);
        IEN = 0;
        wait_valid();
        check("drop_vector", vector, 8'hC7);
        accept();
        cyc(G + 5);
        check("drop_falls", falls - f0, 2);
        check("drop_idle", busy, 0);
        // reset in the middle of PULSE2
        pic_vec = 8'h99;
        INT = 1; IEN = 1;
        for (int k = 0; k < 50 && !(pulse_no == 2 && !INTA); k++) cyc(1);
        check("p2_reached", pulse_no, 2);
        reset = 1;
        cyc(1);
        check("mid_inta", INTA, 1);
        check("mid_valid", vectorValid, 0);
        check("mid_vector", vector, 8'h00);
        check("mid_busy", busy, 0);
        pic_vec = 8'h5A; exp_q.push_back(8'h5A); f0 = falls;
        reset = 0;
        cyc(1); check("rlat1", INTA, 1);
        cyc(1); check("rlat2", INTA, 1);
        cyc(1); check("rlat3", INTA, 0);
        INT = 0;
        wait_valid();
        check("reset_vector", vector, 8'h5A);
        accept();
        cyc(G);
        check("reset_falls", falls - f0, 2);
        // back-to-back with INT held and ready tied high
        pic_vec = 8'h40; exp_q.push_back(8'h40); exp_q.push_back(8'h43); f0 = falls;
        INT = 1; vectorReady = 1;
        wait_valid();
        pic_vec = 8'h43;
        cyc(1); check("b2b_accept", vectorValid, 0);
        for (int i = 0; i < G; i++) begin cyc(1); check("b2b_holdoff", INTA, 1); end
        cyc(1); check("b2b_restart", INTA, 0);
        wait_valid();
        cyc(1);
        INT = 0; vectorReady = 0;
        cyc(G + 2);
        check("b2b_falls", falls - f0, 4);
        check("sb_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
